// File: rtl/intersection_sequencer_if.sv
// Signal bundle between the intersection sequencer and board I/O.
//   Board -> sequencer: ns_car, ew_car (level sensors), ped_req (synchronised push-button)
//   Sequencer -> board: ns_g/ns_y/ns_r, ew_g/ew_y/ew_r lamps, walk lamp, ped_wait,
//                       tick (observation), phase[2:0] (current state)
// master: board/environment side. slave: sequencer side.
interface intersection_sequencer_if;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic       ns_g;
  logic       ns_y;
  logic       ns_r;
  logic       ew_g;
  logic       ew_y;
  logic       ew_r;
  logic       walk;
  logic       ped_wait;
  logic       tick;
  logic [2:0] phase;

  modport master (
    output ns_car, ew_car, ped_req,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait, tick, phase
  );

  modport slave (
    input  ns_car, ew_car, ped_req,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait, tick, phase
  );
endinterface

// File: rtl/intersection_sequencer.sv
// Four-phase intersection controller with demand-driven green extension and an
// exclusive all-red pedestrian WALK phase.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : intersection_sequencer_if.slave
//          in : ns_car, ew_car, ped_req
//          out: NS/EW lamps, walk, ped_wait, tick, phase
// Timing is in ticks; one tick every CLKS_PER_TICK clocks. Sensors and the
// pedestrian latch are only looked at on tick cycles.
module intersection_sequencer #(
  parameter int unsigned CLKS_PER_TICK = 4,
  parameter int unsigned GREEN_MIN     = 5,
  parameter int unsigned GREEN_MAX     = 10,
  parameter int unsigned YELLOW_T      = 2,
  parameter int unsigned ALLRED_T      = 1,
  parameter int unsigned WALK_T        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  intersection_sequencer_if.slave  bus
);

  localparam int unsigned DivW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  // Counter must hold the last value of the longest phase.
  localparam int unsigned MaxA   = (GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T;
  localparam int unsigned MaxB   = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [DivW-1:0] DivLast       = DivW'(CLKS_PER_TICK - 1);
  localparam logic [CntW-1:0] GreenMinLast  = CntW'(GREEN_MIN - 1);
  localparam logic [CntW-1:0] GreenMaxLast  = CntW'(GREEN_MAX - 1);
  localparam logic [CntW-1:0] YellowLast    = CntW'(YELLOW_T - 1);
  localparam logic [CntW-1:0] AllRedLast    = CntW'(ALLRED_T - 1);
  localparam logic [CntW-1:0] WalkLast      = CntW'(WALK_T - 1);

  typedef enum logic [2:0] {
    StNsG    = 3'd0,
    StNsY    = 3'd1,
    StAllRed = 3'd2,
    StEwG    = 3'd3,
    StEwY    = 3'd4,
    StWalk   = 3'd5
  } state_e;

  typedef enum logic {
    DirNs = 1'b0,
    DirEw = 1'b1
  } dir_e;

  state_e          state_q, state_d;
  dir_e            next_dir_q, next_dir_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ped_q, ped_d;

  logic tick;
  logic green_min_met;
  logic green_at_max;
  state_e dir_green;

  // ---------------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------------
  assign tick  = (div_q == DivLast);

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase sequencing
  // ---------------------------------------------------------------------------
  assign green_min_met = (cnt_q >= GreenMinLast);
  assign green_at_max  = (cnt_q == GreenMaxLast);
  assign dir_green     = (next_dir_q == DirNs) ? StNsG : StEwG;

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;

    case (state_q)
      StNsG: begin
        // Leave early only after the minimum, and only if someone is waiting.
        if (tick && green_min_met && (bus.ew_car || ped_q || green_at_max)) begin
          state_d = StNsY;
        end
      end
      StNsY: begin
        if (tick && (cnt_q == YellowLast)) begin
          state_d    = StAllRed;
          next_dir_d = DirEw;
        end
      end
      StEwG: begin
        if (tick && green_min_met && (bus.ns_car || ped_q || green_at_max)) begin
          state_d = StEwY;
        end
      end
      StEwY: begin
        if (tick && (cnt_q == YellowLast)) begin
          state_d    = StAllRed;
          next_dir_d = DirNs;
        end
      end
      StAllRed: begin
        if (tick && (cnt_q == AllRedLast)) begin
          state_d = ped_q ? StWalk : dir_green;
        end
      end
      StWalk: begin
        // WALK is already all-red, so it hands straight over to the next green.
        if (tick && (cnt_q == WalkLast)) begin
          state_d = dir_green;
        end
      end
      default: begin
        // Encodings 6/7: recover without waiting for a tick.
        state_d = StNsG;
      end
    endcase
  end

  // Phase counter: restarts on every state change, otherwise advances on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pedestrian latch; the clear on WALK entry overrides a same-cycle request.
  // ---------------------------------------------------------------------------
  always_comb begin
    ped_d = ped_q;
    if (bus.ped_req && (state_q != StWalk)) begin
      ped_d = 1'b1;
    end
    if ((state_d == StWalk) && (state_q != StWalk)) begin
      ped_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StNsG;
      next_dir_q <= DirEw;
      div_q      <= '0;
      cnt_q      <= '0;
      ped_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ped_q      <= ped_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lamp decode (state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ns_g = 1'b0;
    bus.ns_y = 1'b0;
    bus.ns_r = 1'b0;
    bus.ew_g = 1'b0;
    bus.ew_y = 1'b0;
    bus.ew_r = 1'b0;
    bus.walk = 1'b0;

    case (state_q)
      StNsG: begin
        bus.ns_g = 1'b1;
        bus.ew_r = 1'b1;
      end
      StNsY: begin
        bus.ns_y = 1'b1;
        bus.ew_r = 1'b1;
      end
      StEwG: begin
        bus.ew_g = 1'b1;
        bus.ns_r = 1'b1;
      end
      StEwY: begin
        bus.ew_y = 1'b1;
        bus.ns_r = 1'b1;
      end
      StWalk: begin
        bus.ns_r = 1'b1;
        bus.ew_r = 1'b1;
        bus.walk = 1'b1;
      end
      default: begin
        // All-red, and also the safe decode for illegal encodings.
        bus.ns_r = 1'b1;
        bus.ew_r = 1'b1;
      end
    endcase
  end

  assign bus.ped_wait = ped_q;
  assign bus.tick     = tick;
  assign bus.phase    = state_q;

  // Exactly one lamp lit per approach.
  assert property (@(posedge clk) $onehot({bus.ns_g, bus.ns_y, bus.ns_r}));
  assert property (@(posedge clk) $onehot({bus.ew_g, bus.ew_y, bus.ew_r}));

endmodule

// File: tb/tb_intersection_sequencer.sv
// Self-checking bench for intersection_sequencer. Expected phase segments
// (phase, length in clocks) and ped_wait probes are queued per scenario, then
// popped and compared as the DUT walks through its phases.
module tb_intersection_sequencer;

  localparam int Clks = 4;

  logic clk;
  logic rst;

  intersection_sequencer_if bus ();

  intersection_sequencer #(
    .CLKS_PER_TICK (Clks),
    .GREEN_MIN     (5),
    .GREEN_MAX     (10),
    .YELLOW_T      (2),
    .ALLRED_T      (1),
    .WALK_T        (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int clks;
  } seg_t;

  typedef struct {
    int cyc;
    int val;
  } probe_t;

  seg_t   exp_q[$];
  probe_t probe_q[$];
  int     ped_cyc_q[$];
  int     cyc;
  int     n_total;
  int     n_bad;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0d, want %0d", tag, cyc, obs, exp);
    end
  endtask

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  function automatic int lamps_for(input int ph);
    case (ph)
      0:       return 7'b1000010;
      1:       return 7'b0100010;
      2:       return 7'b0010010;
      3:       return 7'b0011000;
      4:       return 7'b0010100;
      5:       return 7'b0010011;
      default: return 0;
    endcase
  endfunction

  function automatic int lamps_now();
    return int'({bus.ns_g, bus.ns_y, bus.ns_r, bus.ew_g, bus.ew_y, bus.ew_r, bus.walk});
  endfunction

  // Leaves the bench at the negedge of cycle 1 after reset release.
  task automatic do_reset();
    rst         = 1'b1;
    bus.ped_req = 1'b0;
    exp_q.delete();
    probe_q.delete();
    ped_cyc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic push_seg(input int ph, input int ticks);
    seg_t s;
    s.ph   = ph;
    s.clks = ticks * Clks;
    exp_q.push_back(s);
  endtask

  task automatic push_probe(input int c, input int v);
    probe_t p;
    p.cyc = c;
    p.val = v;
    probe_q.push_back(p);
  endtask

  // Apply this cycle's stimulus, run due probes, advance one clock.
  task automatic step();
    bus.ped_req = 1'b0;
    if (ped_cyc_q.size() > 0 && ped_cyc_q[0] == cyc) begin
      bus.ped_req = 1'b1;
      void'(ped_cyc_q.pop_front());
    end
    if (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
      check_eq($sformatf("ped_wait@%0d", cyc), int'(bus.ped_wait), probe_q[0].val);
      void'(probe_q.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string name);
    seg_t e;
    int   len;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({name, " phase"}, int'(bus.phase), e.ph);
      len = 0;
      while (int'(bus.phase) == e.ph && len < e.clks + 16) begin
        check_eq({name, " lamps"}, lamps_now(), lamps_for(e.ph));
        step();
        len++;
      end
      check_eq($sformatf("%s len ph%0d", name, e.ph), len, e.clks);
    end
    check_eq({name, " probes_left"}, probe_q.size(), 0);
    bus.ped_req = 1'b0;
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    cyc         = 0;
    rst         = 1'b1;
    bus.ns_car  = 1'b0;
    bus.ew_car  = 1'b0;
    bus.ped_req = 1'b0;

    // Reset state and tick generation.
    do_reset();
    check_eq("rst phase", int'(bus.phase), 0);
    check_eq("rst lamps", lamps_now(), 7'b1000010);
    check_eq("rst ped_wait", int'(bus.ped_wait), 0);
    for (int c = 1; c <= 40; c++) begin
      check_eq($sformatf("tick@%0d", c), int'(bus.tick), (c % 4 == 0) ? 1 : 0);
      @(negedge clk);
    end

    // Default cycle, no demand.
    do_reset();
    push_seg(0, 10); push_seg(1, 2); push_seg(2, 1);
    push_seg(3, 10); push_seg(4, 2); push_seg(2, 1); push_seg(0, 10);
    drain("default");

    // EW demand held: NS green cut to minimum, EW green runs to maximum.
    bus.ew_car = 1'b1;
    do_reset();
    push_seg(0, 5); push_seg(1, 2); push_seg(2, 1);
    push_seg(3, 10); push_seg(4, 2); push_seg(2, 1); push_seg(0, 5);
    drain("demand");
    bus.ew_car = 1'b0;

    // Pedestrian request during NS green, second request ignored in WALK.
    do_reset();
    ped_cyc_q.push_back(6);
    ped_cyc_q.push_back(40);
    push_probe(5, 0);
    push_probe(7, 1);
    push_probe(33, 0);
    push_probe(41, 0);
    push_probe(60, 0);
    push_seg(0, 5); push_seg(1, 2); push_seg(2, 1); push_seg(5, 4);
    push_seg(3, 10); push_seg(4, 2); push_seg(2, 1); push_seg(0, 10);
    drain("ped");

    // Request in the ALL_RED->WALK cycle: clear wins, no second WALK.
    do_reset();
    ped_cyc_q.push_back(6);
    ped_cyc_q.push_back(32);
    push_probe(31, 1);
    push_probe(33, 0);
    push_probe(34, 0);
    push_probe(90, 0);
    push_seg(0, 5); push_seg(1, 2); push_seg(2, 1); push_seg(5, 4);
    push_seg(3, 10); push_seg(4, 2); push_seg(2, 1); push_seg(0, 10);
    drain("collide");

    // Reset mid EW_Y (cnt=1) with a pending request.
    do_reset();
    ped_cyc_q.push_back(95);
    while (cyc < 97) step();
    check_eq("mid pre phase", int'(bus.phase), 4);
    check_eq("mid pre ped_wait", int'(bus.ped_wait), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid phase", int'(bus.phase), 0);
    check_eq("mid lamps", lamps_now(), 7'b1000010);
    check_eq("mid ped_wait", int'(bus.ped_wait), 0);
    check_eq("mid tick0", int'(bus.tick), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("mid tick%0d", k), int'(bus.tick), (k == 3) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/intersection_sequencer.md
Name: intersection_sequencer

Overview:
- Top-level controller for the four-phase intersection. Generates the per-second tick from the system clock and sequences NS/EW green, yellow and all-red phases.
- Adds demand-driven green extension from vehicle sensors, plus a latched pedestrian request served by an exclusive all-red WALK phase.
- Sits between board I/O (sensors, push-button) and the lamp drivers.

Parameters:
- CLKS_PER_TICK, 4: clock cycles per tick. Board build overrides to 100_000_000.
- GREEN_MIN, 5: minimum green duration in ticks, >=1.
- GREEN_MAX, 10: maximum green duration in ticks, >= GREEN_MIN.
- YELLOW_T, 2: yellow duration in ticks, >=1.
- ALLRED_T, 1: all-red clearance duration in ticks, >=1.
- WALK_T, 4: pedestrian walk duration in ticks, >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ns_car  in  1  vehicle waiting on NS approach (level)
- ew_car  in  1  vehicle waiting on EW approach (level)
- ped_req  in  1  pedestrian button, any width pulse >=1 cycle (already synchronised)
- ns_g, ns_y, ns_r  out  1 each  NS lamps
- ew_g, ew_y, ew_r  out  1 each  EW lamps
- walk  out  1  pedestrian walk lamp
- ped_wait  out  1  request latched, not yet served
- tick  out  1  internal one-cycle tick pulse, for observation
- phase  out  3  current state: 0 NS_G, 1 NS_Y, 2 ALL_RED, 3 EW_G, 4 EW_Y, 5 WALK

Behaviour:
- Tick divider:
  - div counts 0..CLKS_PER_TICK-1, then wraps.
  - tick=1 exactly in the cycle div==CLKS_PER_TICK-1.
  - After rst deasserts, the first tick is in the CLKS_PER_TICK-th cycle.
- Phase counter:
  - cnt is wide enough for max(GREEN_MAX, WALK_T).
  - cnt changes only on tick. It resets to 0 on every state change, else increments.
  - A phase of N ticks exits on the tick where cnt==N-1. The state changes at the clock edge ending that tick cycle.
- State transitions (all evaluated only on tick):
  - NS_G -> NS_Y when cnt>=GREEN_MIN-1 AND (ew_car OR ped_pending OR cnt==GREEN_MAX-1).
  - NS_Y -> ALL_RED after YELLOW_T ticks; next_dir<=EW.
  - EW_G -> EW_Y under the same rule, with ns_car replacing ew_car.
  - EW_Y -> ALL_RED after YELLOW_T ticks; next_dir<=NS.
  - ALL_RED, after ALLRED_T ticks:
    - if ped_pending -> WALK;
    - else -> NS_G if next_dir==NS, else EW_G.
  - WALK -> next_dir green after WALK_T ticks. No second all-red.
- Sensor sampling:
  - Sensors and ped_pending are sampled only on tick.
  - No demand means green runs exactly GREEN_MAX ticks. Alternation is always enforced; no phase is skipped.
- Pedestrian latch:
  - ped_pending is set in any cycle ped_req=1, except while in WALK, where requests are ignored.
  - ped_pending clears at the edge where the state becomes WALK.
  - If set and clear coincide, the clear wins.
  - ped_wait = ped_pending.
- Lamp outputs:
  - Decoded combinationally from the state only.
  - NS_G: ns_g, ew_r. NS_Y: ns_y, ew_r. EW_G: ew_g, ns_r. EW_Y: ew_y, ns_r.
  - ALL_RED: ns_r, ew_r. WALK: ns_r, ew_r, walk.
  - Exactly one lamp per direction is on at all times. Both green/yellow is never allowed.
- Reset (synchronous, effective at the next edge, including mid-phase):
  - state=NS_G, cnt=0, div=0, ped_pending=0, next_dir=EW.
  - Outputs after reset: ns_g=1, ew_r=1, others 0, walk=0, ped_wait=0, tick=0, phase=0.
- Illegal state encodings (6, 7) go to NS_G with cnt=0 on the next clock. All lamp outputs are red-only while in them.

Test Plan:
- Tick generation: reset then run 40 clocks -> tick high 1 cycle at clocks 4, 8, ..., 40 after rst release, never 2 consecutive cycles.
- Default cycle: ns_car=ew_car=ped_req=0 -> phase sequence 0(10 ticks) 1(2) 2(1) 3(10) 4(2) 2(1) 0. One-hot-per-direction lamp check every cycle.
- Demand exit: ew_car=1 held from reset -> NS_G exits after exactly 5 ticks (20 clocks). With ns_car=0, EW_G lasts 10 ticks.
- Pedestrian request:
  - 1-cycle ped_req at tick 2 of NS_G -> ped_wait=1 next cycle.
  - Sequence NS_G(5) NS_Y(2) ALL_RED(1) WALK(4, walk=1, both reds) EW_G.
  - ped_wait=0 from WALK entry.
  - ped_req pulsed during WALK leaves ped_wait=0.
- Reset mid-phase: assert rst for 1 cycle during EW_Y cnt=1 -> next cycle phase=0, ns_g=1, ew_r=1, ped_wait=0, and the next tick occurs 4 clocks later.
- Set/clear collision: ped_req high in the cycle ALL_RED->WALK occurs -> ped_wait=0 after the edge, and no second WALK follows.
